// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Fetch-stage controller. Owns the program counter, issues instruction-memory
// requests over a req/ack handshake and loads the IF/ID pipeline register.
// ID-stage stalls freeze IF/ID (a word that arrives during a stall is parked
// in a one-entry hold buffer). EX-stage redirects flush IF/ID and retarget the
// PC. A redirect that lands while a request is still outstanding sends the
// FSM to KILL, which waits out the old request and throws its data away.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   TIMEOUT   cycles of req-without-ack before fetch_err_o sets (1..255)
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   stall_i        ID hazard stall, IF/ID holds while high
//   br_taken_i     one-cycle EX redirect pulse
//   br_target_i    redirect address (low two bits ignored)
//   imem_req_o     instruction-memory request
//   imem_addr_o    request address, stable until ack
//   imem_ack_i     memory accepts request, imem_rdata_i valid same cycle
//   imem_rdata_i   instruction word
//   pc_o           next address to fetch
//   ifid_valid_o   IF/ID holds a live instruction
//   ifid_instr_o   IF/ID instruction word
//   ifid_npc_o     IF/ID PC+4 of that instruction
//   fetch_err_o    sticky memory-timeout flag
//   perf_fetch_o   count of valid IF/ID loads
//   perf_bubble_o  count of bubble cycles since leaving IDLE
//
// Build option:
//   IF_PERF_CNT_EN  when defined, the two perf counters are built; otherwise
//                   perf_fetch_o and perf_bubble_o are tied to zero.
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_npc_o,
  output logic        fetch_err_o,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_bubble_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_e;

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_npc_q, ifid_npc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_npc_q, hold_npc_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;

  logic        ack_w;
  logic [31:0] pc_inc_w;
  logic [31:0] br_target_w;

  // An ack only counts while a request is actually on the bus; stray acks in
  // IDLE or HOLD are ignored.
  assign ack_w       = imem_ack_i & req_q;
  assign pc_inc_w    = pc_q + 32'd4;
  assign br_target_w = br_target_i & 32'hFFFF_FFFC;

  // Next-state logic. Redirect is checked first in every state so it always
  // beats a stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    hold_instr_d = hold_instr_q;
    hold_npc_d   = hold_npc_q;
    tmo_d        = tmo_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (br_taken_i) begin
          pc_d = br_target_w;
        end
        state_d = FETCH;
      end

      FETCH: begin
        if (br_taken_i) begin
          pc_d         = br_target_w;
          ifid_valid_d = 1'b0;
          // Without an ack the old request is still in flight and must be
          // drained before the new address can go out.
          state_d      = ack_w ? FETCH : KILL;
        end else if (ack_w) begin
          pc_d = pc_inc_w;
          if (stall_i) begin
            hold_instr_d = imem_rdata_i;
            hold_npc_d   = pc_inc_w;
            state_d      = HOLD;
          end else begin
            ifid_instr_d = imem_rdata_i;
            ifid_npc_d   = pc_inc_w;
            ifid_valid_d = 1'b1;
          end
        end else if (!stall_i) begin
          ifid_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (br_taken_i) begin
          pc_d         = br_target_w;
          ifid_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (!stall_i) begin
          ifid_instr_d = hold_instr_q;
          ifid_npc_d   = hold_npc_q;
          ifid_valid_d = 1'b1;
          state_d      = FETCH;
        end
      end

      KILL: begin
        if (br_taken_i) begin
          pc_d = br_target_w;
        end
        ifid_valid_d = 1'b0;
        if (ack_w) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout counter saturates at TMO_MAX; the flag sets on the same edge
    // the counter reaches it and stays set until reset.
    if (ack_w) begin
      tmo_d = 8'd0;
    end else if (req_q && (tmo_q != TMO_MAX)) begin
      tmo_d = tmo_q + 8'd1;
      if (tmo_d == TMO_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  // The bus outputs are registered. In KILL the address register keeps the
  // in-flight address while pc_q already points at the redirect target; in
  // every other state it simply follows the PC.
  always_comb begin
    req_d  = (state_d == FETCH) || (state_d == KILL);
    addr_d = (state_d == KILL) ? addr_q : pc_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_npc_q   <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_npc_q   <= 32'd0;
      tmo_q        <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
      hold_instr_q <= hold_instr_d;
      hold_npc_q   <= hold_npc_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign pc_o         = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_npc_o   = ifid_npc_q;
  assign fetch_err_o  = err_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_bubble_q;
  logic        perf_load_w;
  logic        perf_bubble_w;

  // A valid IF/ID load happens on an unstalled ack in FETCH or when HOLD
  // releases its buffer; a redirect cancels either.
  assign perf_load_w   = !br_taken_i && !stall_i &&
                         (((state_q == FETCH) && ack_w) || (state_q == HOLD));
  assign perf_bubble_w = (state_q != IDLE) && !ifid_valid_q;

  // Free-running wrapping performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= 32'd0;
      perf_bubble_q <= 32'd0;
    end else begin
      if (perf_load_w) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (perf_bubble_w) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_bubble_o = perf_bubble_q;
`else
  assign perf_fetch_o  = 32'd0;
  assign perf_bubble_o = 32'd0;
`endif

endmodule
